// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling, one-cycle rx_done/frame_err pulses.
// Latency: rx_done one cycle after the stop-bit sample; no backpressure, data_rx holds until the next good frame.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic       rx_in,
  output logic [7:0] data_rx,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int BPS_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BPS_CNT / 2;
  localparam int CW       = $clog2(BPS_CNT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_bcnt, w_bcnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_done, w_done_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          r_sync1, r_rx_s, r_rx_d;
  logic          w_fall;

  // Synchroniser and edge-history flops idle at 1 so a low line after clear is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !in) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n || !in) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_bcnt_nxt = '0;
        if (w_fall) w_state_nxt = START;
      end
      START: begin
        if (r_bcnt == CW'(HALF_CNT - 1)) begin
          w_bcnt_nxt = '0;
          w_idx_nxt  = '0;
          // A start bit that is high again at mid-bit was a glitch.
          w_state_nxt = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_bcnt == CW'(BPS_CNT - 1)) begin
          w_bcnt_nxt  = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_idx_nxt   = r_idx + 1'b1;
          if (r_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_bcnt == CW'(BPS_CNT - 1)) begin
          w_bcnt_nxt  = '0;
          w_state_nxt = IDLE;
          if (r_rx_s) begin
            w_data_nxt = r_shift;
            w_done_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign data_rx   = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clk/bit: frame table plus reset, glitch and enable-drop sequences.
module tb_uart_rx_byte;

  localparam int BPS  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n, in, rx_in;
  logic [7:0] data_rx;
  logic       rx_done, frame_err, busy;

  uart_rx_byte #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .rx_in(rx_in),
    .data_rx(data_rx), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, busy_rises = 0;
  int last_done_cyc = 0, last_err_cyc = 0, busy_rise_cyc = 0, fall_cyc = 0;
  logic prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
    if (frame_err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
    if (rx_done === 1'b1 || frame_err === 1'b1) begin
      checks++;
      if ((rx_done && frame_err) || (rx_done && prev_done) || (frame_err && prev_err)) begin
        failures++;
        $display("FAIL pulse_shape cyc=%0d rx_done=%b frame_err=%b prev_done=%b prev_err=%b required single exclusive pulses",
                 cyc, rx_done, frame_err, prev_done, prev_err);
      end
    end
    if (busy === 1'b1 && prev_busy !== 1'b1) begin busy_rises++; busy_rise_cyc = cyc; end
    prev_done = (rx_done === 1'b1);
    prev_err  = (frame_err === 1'b1);
    prev_busy = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (BPS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int k = 0; k < 8; k++) send_bit(d[k]);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop;
    int         gap;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, e0, b0;
    vecs[0] = '{din: 8'h55, stop: 1'b1, gap: 20, exp_done: 1, exp_err: 0, exp_data: 8'h55};
    vecs[1] = '{din: 8'hA5, stop: 1'b1, gap: 0,  exp_done: 1, exp_err: 0, exp_data: 8'hA5};
    vecs[2] = '{din: 8'h3C, stop: 1'b1, gap: 20, exp_done: 1, exp_err: 0, exp_data: 8'h3C};
    vecs[3] = '{din: 8'h12, stop: 1'b1, gap: 20, exp_done: 1, exp_err: 0, exp_data: 8'h12};
    vecs[4] = '{din: 8'hFF, stop: 1'b0, gap: 20, exp_done: 0, exp_err: 1, exp_data: 8'h12};

    rst_n = 1'b0; in = 1'b1; rx_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("reset_outputs_%0d", i), {20'd0, data_rx, rx_done, frame_err, busy}, 32'd0);
      rx_in = ~rx_in;
    end
    rx_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_no_done", done_cnt, 0);
    check("idle_no_err", err_cnt, 0);
    check("idle_no_busy", busy_rises, 0);
    check("idle_data", data_rx, 8'h00);
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; e0 = err_cnt; b0 = busy_rises;
      send_frame(vecs[v].din, vecs[v].stop);
      rx_in = 1'b1;
      repeat (vecs[v].gap) @(posedge clk);
      #1;
      check($sformatf("v%0d_done_count", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("v%0d_err_count", v), err_cnt - e0, vecs[v].exp_err);
      check($sformatf("v%0d_data", v), data_rx, vecs[v].exp_data);
      check($sformatf("v%0d_busy_rise_lat", v), busy_rise_cyc - fall_cyc, 3);
      if (vecs[v].exp_done != 0)
        check($sformatf("v%0d_done_lat", v), last_done_cyc - fall_cyc, 2 + HALF + 9 * BPS + 1);
      if (vecs[v].exp_err != 0)
        check($sformatf("v%0d_err_lat", v), last_err_cyc - fall_cyc, 2 + HALF + 9 * BPS + 1);
      check($sformatf("v%0d_busy_rises", v), busy_rises - b0, 1);
    end

    // Four-cycle low glitch: START sees the line high again at mid-bit.
    d0 = done_cnt; e0 = err_cnt; b0 = busy_rises;
    rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_busy_pulsed", busy_rises - b0, 1);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_err", err_cnt - e0, 0);
    check("glitch_data_kept", data_rx, 8'h12);

    // Drop the enable mid data bit 3, then recover with a clean frame.
    d0 = done_cnt; e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rx_in = 1'b1;
    repeat (8) @(posedge clk);
    #1 in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("en_drop_busy", busy, 1'b0);
    check("en_drop_data", data_rx, 8'h00);
    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (40) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (10) @(posedge clk);
    #1 in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("en_drop_no_done", done_cnt - d0, 0);
    check("en_drop_no_err", err_cnt - e0, 0);
    check("en_drop_idle", busy, 1'b0);
    send_frame(8'hC3, 1'b1);
    rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("recover_data", data_rx, 8'hC3);
    check("recover_done_count", done_cnt - d0, 1);
    check("recover_done_lat", last_done_cyc - fall_cyc, 2 + HALF + 9 * BPS + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
